// File: rtl/weight_update_if.sv
// rtl/weight_update_if.sv - request/response bundle between the forward datapath and weight_update.
interface weight_update_if #(
    parameter int W_WIDTH = 21
);
    logic                      en_i;
    logic                      start_i;
    logic        [3:0]         target_i;
    logic        [20:0]        predicted_i;
    logic        [3:0]         feature_i;
    logic                      busy_o;
    logic                      done_o;
    logic signed [26:0]        grad_o;
    logic signed [W_WIDTH-1:0] weight_o;

    modport slave (
        input  en_i, start_i, target_i, predicted_i, feature_i,
        output busy_o, done_o, grad_o, weight_o
    );

    modport master (
        output en_i, start_i, target_i, predicted_i, feature_i,
        input  busy_o, done_o, grad_o, weight_o
    );
endinterface

// File: rtl/weight_update.sv
// rtl/weight_update.sv - SGD weight update w -= (2*(pred-target)*x) >>> LR_SHIFT via a 4-step shift-add multiply.
// Define WEIGHT_SAT_EN to clamp the new weight instead of letting it wrap.
module weight_update #(
    parameter int                  W_WIDTH  = 21,
    parameter int                  LR_SHIFT = 4,
    parameter logic signed [W_WIDTH-1:0] W_INIT = '0
) (
    input logic         clk_i,
    input logic         rst_i,
    weight_update_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ERR, MUL, UPD} state_t;

    state_t                    state_q;
    logic                      busy_q;
    logic                      done_q;
    logic        [3:0]         tgt_q;
    logic        [20:0]        pred_q;
    logic        [3:0]         feat_q;
    logic signed [21:0]        err_q;
    logic signed [25:0]        acc_q;
    logic        [1:0]         cnt_q;
    logic signed [26:0]        grad_q;
    logic signed [W_WIDTH-1:0] weight_q;

    logic signed [25:0]        err_ext_d;
    logic signed [26:0]        grad_d;
    logic signed [W_WIDTH-1:0] weight_d;

    assign err_ext_d = {{4{err_q[21]}}, err_q};
    assign grad_d    = {acc_q, 1'b0};

`ifdef WEIGHT_SAT_EN
    localparam logic signed [27:0] W_MAX = (28'sd1 <<< (W_WIDTH - 1)) - 28'sd1;
    localparam logic signed [27:0] W_MIN = -(28'sd1 <<< (W_WIDTH - 1));

    logic signed [27:0] diff_d;

    always_comb begin
        diff_d = 28'(weight_q) - (28'(grad_d) >>> LR_SHIFT);
        if (diff_d > W_MAX) begin
            weight_d = W_WIDTH'(W_MAX);
        end else if (diff_d < W_MIN) begin
            weight_d = W_WIDTH'(W_MIN);
        end else begin
            weight_d = diff_d[W_WIDTH-1:0];
        end
    end
`else
    // Truncating the shifted gradient first gives the same modulo-2^W result.
    assign weight_d = weight_q - W_WIDTH'(grad_d >>> LR_SHIFT);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tgt_q    <= '0;
            pred_q   <= '0;
            feat_q   <= '0;
            err_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            grad_q   <= '0;
            weight_q <= W_INIT;
        end else begin
            // done is a strict one-cycle pulse, even while stalled.
            done_q <= 1'b0;
            if (bus.en_i) begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_i) begin
                            tgt_q   <= bus.target_i;
                            pred_q  <= bus.predicted_i;
                            feat_q  <= bus.feature_i;
                            busy_q  <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                    ERR: begin
                        err_q   <= $signed({1'b0, pred_q}) - $signed({18'b0, tgt_q});
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= MUL;
                    end
                    MUL: begin
                        if (feat_q[cnt_q]) begin
                            acc_q <= acc_q + (err_ext_d <<< cnt_q);
                        end
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= UPD;
                        end
                    end
                    UPD: begin
                        grad_q   <= grad_d;
                        weight_q <= weight_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.grad_o   = grad_q;
    assign bus.weight_o = weight_q;
endmodule
